// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants and types for the 1-to-2 stream demultiplexer.
// Provides the default payload width, the packet-lock state encoding and
// the route encoding used to steer beats to output A or B.
package stream_demux_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Route encoding: value of in_sel (or the locked route) selecting an output.
  localparam logic ROUTE_A = 1'b0;
  localparam logic ROUTE_B = 1'b1;

  // Packet-lock states, used only when STREAM_DEMUX_PKT_LOCK_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } lock_state_e;

endpackage

// File: rtl/stream_demux_slot.sv
// stream_demux_slot: one-entry output register of the demultiplexer.
// Holds one beat (data + last) for a consumer. It can drain and load in the
// same cycle, which gives full throughput with a single entry.
module stream_demux_slot #(
  parameter int WIDTH = stream_demux_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             free
);

  // The slot can take a new beat when empty or when its beat leaves this cycle.
  assign free = !valid || ready;

  // Slot register: load wins over drain; data/last hold after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the payload is reset as well as valid, so the outputs read zero
      // after reset instead of leftover data from before it.
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would create order-dependent simulation.
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
        last  <= load_last;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-2 valid/ready stream demultiplexer.
// Each input beat is routed to output A (in_sel=0) or B (in_sel=1) through a
// one-entry slot per output, for 1-cycle latency and full throughput.
// Optional feature macro: STREAM_DEMUX_PKT_LOCK_EN -- when defined, the route
// chosen by the first beat of a packet is held until the beat with in_last=1.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_last,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_last,
  output logic             out_b_valid,
  input  logic             out_b_ready
);

  logic route;
  logic a_free;
  logic b_free;
  logic accept;
  logic load_a;
  logic load_b;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
  lock_state_e state;
  lock_state_e state_nxt;

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Route decode: a locked packet overrides in_sel.
  assign route = (state == LOCK_A) ? ROUTE_A :
                 (state == LOCK_B) ? ROUTE_B : in_sel;

  // Next-state logic: only an accepted beat can move the lock.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (accept) begin
      if (in_last) begin
        state_nxt = IDLE;
      end else if (state == IDLE) begin
        state_nxt = (in_sel == ROUTE_B) ? LOCK_B : LOCK_A;
      end
    end
  end
`else
  // Per-beat routing; in_last is only forwarded with the beat.
  assign route = in_sel;
`endif

  // Handshake: accept when the slot picked by route can take a beat.
  assign in_ready = (route == ROUTE_B) ? b_free : a_free;
  assign accept   = in_valid && in_ready;
  assign load_a   = accept && (route == ROUTE_A);
  assign load_b   = accept && (route == ROUTE_B);

  stream_demux_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (out_a_ready),
    .valid     (out_a_valid),
    .data      (out_a_data),
    .last      (out_a_last),
    .free      (a_free)
  );

  stream_demux_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (out_b_ready),
    .valid     (out_b_valid),
    .data      (out_b_data),
    .last      (out_b_last),
    .free      (b_free)
  );

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: scoreboard bench for stream_demux.
// A reference model tracks each output as a queue of outstanding beats and,
// when STREAM_DEMUX_PKT_LOCK_EN is defined, the destination of the open packet.
module tb_stream_demux;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_a_data;
  logic         out_a_last;
  logic         out_a_valid;
  logic         out_a_ready;
  logic [W-1:0] out_b_data;
  logic         out_b_last;
  logic         out_b_valid;
  logic         out_b_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_b   = 0;

  // Outstanding beats per output, {last, data}; an output holds at most one.
  logic [W:0] qa[$];
  logic [W:0] qb[$];
  // Destination of the currently open packet, -1 when none is open.
  int pkt_dest = -1;

  stream_demux #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_last     (in_last),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_a_data  (out_a_data),
    .out_a_last  (out_a_last),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b_data  (out_b_data),
    .out_b_last  (out_b_last),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs must be valid exactly when the model has a beat pending;
  // a consumed beat is popped and compared.
  always @(negedge clk) begin
    if (!rst) begin
      logic [W:0] e;
      check("a_valid", out_a_valid, qa.size() != 0);
      check("b_valid", out_b_valid, qb.size() != 0);
      if (qa.size() != 0 && out_a_ready) begin
        e = qa.pop_front();
        check("a_data", out_a_data, e[W-1:0]);
        check("a_last", out_a_last, e[W]);
      end
      if (qb.size() != 0 && out_b_ready) begin
        e = qb.pop_front();
        check("b_data", out_b_data, e[W-1:0]);
        check("b_last", out_b_last, e[W]);
        cnt_b++;
      end
    end
  end

  // Model: after the monitor has drained, decide route and acceptance and
  // push the expected beat onto the routed output's queue.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      qa.delete();
      qb.delete();
      pkt_dest = -1;
    end else begin
      int r;
      logic exp_rdy;
      r = (pkt_dest >= 0) ? pkt_dest : int'(in_sel);
      exp_rdy = (r == 1) ? (qb.size() == 0) : (qa.size() == 0);
      check("in_ready", in_ready, exp_rdy);
      if (in_valid && exp_rdy) begin
        if (r == 1) qb.push_back({in_last, in_data});
        else        qa.push_back({in_last, in_data});
`ifdef STREAM_DEMUX_PKT_LOCK_EN
        if (in_last)           pkt_dest = -1;
        else if (pkt_dest < 0) pkt_dest = r;
`endif
      end
    end
  end

  // Drive one cycle of inputs, then advance to just after the next rising edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic s,
                       input logic l, input logic ra, input logic rb);
    in_valid    = v;
    in_data     = d;
    in_sel      = s;
    in_last     = l;
    out_a_ready = ra;
    out_b_ready = rb;
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check outputs clear at once, release away from the edge.
  task automatic mid_reset();
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("rst_a_valid", out_a_valid, 1'b0);
    check("rst_b_valid", out_b_valid, 1'b0);
    check("rst_a_data", out_a_data, 0);
    check("rst_b_data", out_b_data, 0);
    check("rst_a_last", out_a_last, 1'b0);
    check("rst_b_last", out_b_last, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_sel = 1'b0; in_last = 1'b0;
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    @(posedge clk);
    #1;
    check("init_a_valid", out_a_valid, 1'b0);
    check("init_b_valid", out_b_valid, 1'b0);
    check("init_a_data", out_a_data, 0);
    rst = 1'b0;
    #1;
    check("init_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Streaming to both outputs with no back-pressure.
    cycle(1, 8'h11, 0, 1, 1, 1);
    cycle(1, 8'h22, 1, 1, 1, 1);
    cycle(1, 8'h33, 0, 1, 1, 1);
    cycle(0, 8'h00, 0, 0, 1, 1);
    cycle(0, 8'h00, 0, 0, 1, 1);

    // Back-pressure on A; B still flows; then drain and load A in one cycle.
    cycle(1, 8'h44, 0, 1, 0, 1);
    cycle(1, 8'h55, 0, 1, 0, 1);
    cycle(1, 8'h66, 1, 1, 0, 1);
    cycle(1, 8'h55, 0, 1, 1, 1);
    cycle(0, 8'h00, 0, 0, 1, 1);
    cycle(0, 8'h00, 0, 0, 1, 1);

    // Full rate to B: 16 beats, each accepted on its own cycle.
    b0 = cnt_b;
    for (int i = 0; i < 16; i++) cycle(1, W'(8'hC0 + i), 1, 1, 1, 1);
    cycle(0, 8'h00, 0, 0, 1, 1);
    cycle(0, 8'h00, 0, 0, 1, 1);
    check("b_burst_count", cnt_b - b0, 16);

    // Packet stimulus: in lock builds A0..A2 go to A; otherwise A1, A2, B0 go to B.
    cycle(1, 8'hA0, 0, 0, 1, 1);
    cycle(1, 8'hA1, 1, 0, 1, 1);
    cycle(1, 8'hA2, 1, 1, 1, 1);
    cycle(1, 8'hB0, 1, 1, 1, 1);
    cycle(0, 8'h00, 0, 0, 1, 1);
    cycle(0, 8'h00, 0, 0, 1, 1);

    // Reset with both slots full.
    cycle(1, 8'h77, 0, 1, 0, 0);
    cycle(1, 8'h88, 1, 1, 0, 0);
    mid_reset();
    cycle(0, 8'h00, 0, 0, 1, 1);

    // Reset mid-packet: the lock must not survive, so C0 (sel=1) goes to B.
    cycle(1, 8'hA0, 0, 0, 1, 1);
    mid_reset();
    b0 = cnt_b;
    cycle(1, 8'hC0, 1, 1, 1, 1);
    cycle(0, 8'h00, 0, 0, 1, 1);
    cycle(0, 8'h00, 0, 0, 1, 1);
    check("c0_on_b", cnt_b - b0, 1);

    // Randomized traffic with random back-pressure on both outputs.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, W'($urandom), $urandom % 2, ($urandom % 3) == 0,
            ($urandom % 4) != 0, ($urandom % 4) != 0);
    end
    repeat (4) cycle(0, 8'h00, 0, 0, 1, 1);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
